sdp_ram_be: RTL and testbench

//   Simple dual-port synchronous RAM: one write port with byte enables, one independent read port.

---
 rtl/sdp_ram_be.sv | 127 ++++++++++++
 tb/tb_sdp_ram_be.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte-enable writes, registered reads and a post-reset clear engine.
// Optional per-word even parity with o_parity_err is enabled by defining RAM_PARITY_EN.
module sdp_ram_be #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_wr_en,
    input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
    input  logic [DATA_WIDTH-1:0]            i_wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_be,
    input  logic                             i_rd_en,
    input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
    output logic [DATA_WIDTH-1:0]            o_rd_data,
    output logic                             o_rd_valid,
`ifdef RAM_PARITY_EN
    output logic                             o_parity_err,
`endif
    output logic                             o_init_busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic                    r_par [DEPTH];
`endif

    logic [DATA_WIDTH-1:0]   w_be_mask;
    logic [DATA_WIDTH-1:0]   w_wr_merged;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_dat;
    logic                    w_rd_bypass;

    always_comb begin
        w_be_mask = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            w_be_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{i_wr_be[i]}};
        end
    end

    assign w_wr_merged = (r_mem[i_wr_addr] & ~w_be_mask) | (i_wr_data & w_be_mask);
    assign w_rd_bypass = i_wr_en && (i_wr_addr == i_rd_addr);

    // The clear engine and user writes share the single memory write port.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = i_wr_addr;
        w_mem_dat  = w_wr_merged;
        if (!i_rst) begin
            if (r_state == ST_INIT) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
                w_mem_dat  = '0;
            end else if (i_wr_en) begin
                w_mem_we   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_dat;
`ifdef RAM_PARITY_EN
            r_par[w_mem_addr] <= ^w_mem_dat;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_clr_cnt    <= '0;
            o_rd_data    <= '0;
            o_rd_valid   <= 1'b0;
            o_init_busy  <= 1'b1;
`ifdef RAM_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
                    o_rd_valid   <= 1'b0;
`ifdef RAM_PARITY_EN
                    o_parity_err <= 1'b0;
`endif
                    r_clr_cnt    <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        o_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    o_rd_valid <= i_rd_en;
`ifdef RAM_PARITY_EN
                    o_parity_err <= 1'b0;
`endif
                    if (i_rd_en) begin
                        // Write-first: a colliding write returns the merged word.
                        if (w_rd_bypass) begin
                            o_rd_data <= w_wr_merged;
                        end else begin
                            o_rd_data <= r_mem[i_rd_addr];
`ifdef RAM_PARITY_EN
                            o_parity_err <= (^r_mem[i_rd_addr]) ^ r_par[i_rd_addr];
`endif
                        end
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench for sdp_ram_be: clear engine, byte enables, write-first collision, reset restart.
module tb_sdp_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        init_busy;
`ifdef RAM_PARITY_EN
    logic        parity_err;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdp_ram_be #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .BYTE_WIDTH(8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_wr_be     (wr_be),
        .i_rd_en     (rd_en),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
`ifdef RAM_PARITY_EN
        .o_parity_err(parity_err),
`endif
        .o_init_busy (init_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk({tag, "_dat"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic run_init(input string tag);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk({tag, "_busy"}, 32'(init_busy), (i < 15) ? 32'd1 : 32'd0);
            chk({tag, "_vld"}, 32'(rd_valid), 32'd0);
            chk({tag, "_dat"}, 32'(rd_data), 32'd0);
        end
    endtask

    task automatic read_all_zero(input string tag);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick();
            chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
            chk({tag, "_dat"}, 32'(rd_data), 32'd0);
        end
        rd_en = 1'b0;
        tick();
        chk({tag, "_vld_off"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;

        // Reset held for three edges, then the clear engine runs for 16 edges.
        tick(); tick(); tick();
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_vld",  32'(rd_valid),  32'd0);
        chk("rst_dat",  32'(rd_data),   32'd0);
        rst = 1'b0;
        run_init("init1");
        read_all_zero("clr1");

        // Full write then read, valid for exactly one cycle.
        do_write(4'd3, 16'hBEEF, 2'b11);
        do_read("wr3", 4'd3, 16'hBEEF);
        tick();
        chk("wr3_vld_drop", 32'(rd_valid), 32'd0);
        chk("wr3_hold",     32'(rd_data),  32'hBEEF);

        // Partial lane write and no-op write.
        do_write(4'd5, 16'hBEEF, 2'b11);
        do_write(4'd5, 16'h1234, 2'b01);
        do_read("be01", 4'd5, 16'hBE34);
        do_write(4'd5, 16'hFFFF, 2'b00);
        do_read("be00", 4'd5, 16'hBE34);

        // Same-address collision returns the merged word.
        do_write(4'd7, 16'hAAAA, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5555; wr_be = 2'b10;
        do_read("wf_same", 4'd7, 16'h55AA);
        wr_en = 1'b0;
        do_read("wf_later", 4'd7, 16'h55AA);

        // Different-address read and write are independent.
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h1111; wr_be = 2'b11;
        do_read("indep_rd", 4'd3, 16'hBEEF);
        wr_en = 1'b0;
        do_read("indep_wr", 4'd8, 16'h1111);

        // Reset mid-stream while writes continue; INIT must ignore both ports.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'($urandom); wr_be = 2'b11;
            if (i == 8) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("rst2_busy", 32'(init_busy), 32'd1);
        chk("rst2_vld",  32'(rd_valid),  32'd0);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd2;
        run_init("init2");
        wr_en = 1'b0; rd_en = 1'b0;
        read_all_zero("clr2");

`ifdef RAM_PARITY_EN
        do_write(4'd9, 16'h0F0F, 2'b11);
        dut.r_mem[9][0] = ~dut.r_mem[9][0];
        do_read("par_flip", 4'd9, 16'h0F0E);
        chk("par_flip_err", 32'(parity_err), 32'd1);
        tick();
        chk("par_err_drop", 32'(parity_err), 32'd0);
        do_write(4'd10, 16'h1234, 2'b11);
        do_read("par_ok", 4'd10, 16'h1234);
        chk("par_ok_err", 32'(parity_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
